// File: rtl/vi_pkg.sv
// Shared constants and the stage-record layout for the multiply pipeline.
package vi_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RAW   = 5;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned PC_W  = 32;

    typedef struct packed {
        logic            valid;
        logic            wr_en;
        logic [RAW-1:0]  addr;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] data;
    } stage_t;

endpackage

// File: rtl/mult_stage_reg.sv
// One multiply pipeline stage register; reset beats flush, flush beats hold.
module mult_stage_reg
    import vi_pkg::*;
#(
    parameter int unsigned XLEN = vi_pkg::XLEN,
    parameter int unsigned RAW  = vi_pkg::RAW
) (
    input  logic            clk_i,
    input  logic            rsn_i,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic            wr_en_i,
    input  logic [RAW-1:0]  addr_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [XLEN-1:0] data_i,
    output logic            valid_o,
    output logic            wr_en_o,
    output logic [RAW-1:0]  addr_o,
    output logic [PC_W-1:0] pc_o,
    output logic [XLEN-1:0] data_o
);

    logic            valid_q;
    logic            wr_en_q;
    logic [RAW-1:0]  addr_q;
    logic [PC_W-1:0] pc_q;
    logic [XLEN-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            valid_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            pc_q    <= '0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            valid_q <= valid_i;
            wr_en_q <= wr_en_i;
            addr_q  <= addr_i;
            pc_q    <= pc_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign wr_en_o = wr_en_q;
    assign addr_o  = addr_q;
    assign pc_o    = pc_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mult_bypass_pipe.sv
// Fixed-latency multiply pipeline with writeback slot and per-port bypass/stall search.
module mult_bypass_pipe
    import vi_pkg::*;
#(
    parameter int unsigned XLEN  = vi_pkg::XLEN,
    parameter int unsigned DEPTH = vi_pkg::DEPTH,
    parameter int unsigned NREAD = 2,
    parameter int unsigned RAW   = vi_pkg::RAW
) (
    input  logic                  clk_i,
    input  logic                  rsn_i,
    input  logic                  issue_valid_i,
    input  logic [XLEN-1:0]       issue_a_i,
    input  logic [XLEN-1:0]       issue_b_i,
    input  logic [RAW-1:0]        issue_addr_i,
    input  logic                  issue_wr_en_i,
    input  logic [31:0]           issue_pc_i,
    input  logic                  hold_i,
    input  logic                  flush_i,
    input  logic [NREAD*RAW-1:0]  rd_addr_i,
    output logic [NREAD-1:0]      byp_en_o,
    output logic [NREAD*XLEN-1:0] byp_data_o,
    output logic                  stall_o,
    output logic                  wb_valid_o,
    output logic [RAW-1:0]        wb_addr_o,
    output logic [XLEN-1:0]       wb_data_o,
    output logic [31:0]           wb_pc_o
);

    logic            valid_d [DEPTH];
    logic            wr_en_d [DEPTH];
    logic [RAW-1:0]  addr_d  [DEPTH];
    logic [31:0]     pc_d    [DEPTH];
    logic [XLEN-1:0] data_d  [DEPTH];

    logic            valid_q [DEPTH];
    logic            wr_en_q [DEPTH];
    logic [RAW-1:0]  addr_q  [DEPTH];
    logic [31:0]     pc_q    [DEPTH];
    logic [XLEN-1:0] data_q  [DEPTH];

    logic [XLEN-1:0]  prod;
    logic [NREAD-1:0] port_stall;

    assign prod = issue_a_i * issue_b_i;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign valid_d[s] = issue_valid_i;
            assign wr_en_d[s] = issue_wr_en_i;
            assign addr_d[s]  = issue_addr_i;
            assign pc_d[s]    = issue_pc_i;
            assign data_d[s]  = prod;
        end else begin : g_body
            assign valid_d[s] = valid_q[s-1];
            assign wr_en_d[s] = wr_en_q[s-1];
            assign addr_d[s]  = addr_q[s-1];
            assign pc_d[s]    = pc_q[s-1];
            assign data_d[s]  = data_q[s-1];
        end

        mult_stage_reg #(
            .XLEN (XLEN),
            .RAW  (RAW)
        ) u_stage (
            .clk_i   (clk_i),
            .rsn_i   (rsn_i),
            .hold_i  (hold_i),
            .flush_i (flush_i),
            .valid_i (valid_d[s]),
            .wr_en_i (wr_en_d[s]),
            .addr_i  (addr_d[s]),
            .pc_i    (pc_d[s]),
            .data_i  (data_d[s]),
            .valid_o (valid_q[s]),
            .wr_en_o (wr_en_q[s]),
            .addr_o  (addr_q[s]),
            .pc_o    (pc_q[s]),
            .data_o  (data_q[s])
        );
    end

    // First match from stage 1 upward is the youngest producer; only stage DEPTH has final data.
    for (genvar k = 0; k < NREAD; k++) begin : g_port
        logic [RAW-1:0]  rd;
        logic            hit;
        logic            stall_k;
        logic            en_k;
        logic [XLEN-1:0] dat_k;

        assign rd = rd_addr_i[k*RAW +: RAW];

        always_comb begin
            hit     = 1'b0;
            stall_k = 1'b0;
            en_k    = 1'b0;
            dat_k   = '0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                if (!hit && (rd != '0) && valid_q[s] && wr_en_q[s] && (addr_q[s] == rd)) begin
                    hit = 1'b1;
                    if (s == DEPTH - 1) begin
                        en_k  = 1'b1;
                        dat_k = data_q[s];
                    end else begin
                        stall_k = 1'b1;
                    end
                end
            end
        end

        assign byp_en_o[k]                 = en_k;
        assign byp_data_o[k*XLEN +: XLEN]  = dat_k;
        assign port_stall[k]               = stall_k;
    end

    assign stall_o    = |port_stall;
    assign wb_valid_o = valid_q[DEPTH-1] & wr_en_q[DEPTH-1];
    assign wb_addr_o  = addr_q[DEPTH-1];
    assign wb_data_o  = data_q[DEPTH-1];
    assign wb_pc_o    = pc_q[DEPTH-1];

endmodule

// File: tb/tb_mult_bypass_pipe.sv
// Bench for mult_bypass_pipe: directed scenarios plus random traffic against an age-list model.
module tb_mult_bypass_pipe;

    localparam int XLEN  = 32;
    localparam int DEPTH = 5;
    localparam int NREAD = 2;
    localparam int RAW   = 5;

    logic                  clk = 1'b0;
    logic                  rsn = 1'b0;
    logic                  issue_valid = 1'b0;
    logic [XLEN-1:0]       issue_a = '0;
    logic [XLEN-1:0]       issue_b = '0;
    logic [RAW-1:0]        issue_addr = '0;
    logic                  issue_wr_en = 1'b0;
    logic [31:0]           issue_pc = '0;
    logic                  hold = 1'b0;
    logic                  flush = 1'b0;
    logic [NREAD*RAW-1:0]  rd_addr = '0;
    logic [NREAD-1:0]      byp_en;
    logic [NREAD*XLEN-1:0] byp_data;
    logic                  stall;
    logic                  wb_valid;
    logic [RAW-1:0]        wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic [31:0]           wb_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_bypass_pipe #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NREAD (NREAD),
        .RAW   (RAW)
    ) dut (
        .clk_i         (clk),
        .rsn_i         (rsn),
        .issue_valid_i (issue_valid),
        .issue_a_i     (issue_a),
        .issue_b_i     (issue_b),
        .issue_addr_i  (issue_addr),
        .issue_wr_en_i (issue_wr_en),
        .issue_pc_i    (issue_pc),
        .hold_i        (hold),
        .flush_i       (flush),
        .rd_addr_i     (rd_addr),
        .byp_en_o      (byp_en),
        .byp_data_o    (byp_data),
        .stall_o       (stall),
        .wb_valid_o    (wb_valid),
        .wb_addr_o     (wb_addr),
        .wb_data_o     (wb_data),
        .wb_pc_o       (wb_pc)
    );

    // In-flight ops tracked by age: age N means the result sits N edges after issue.
    typedef struct {
        int          addr;
        bit          wr_en;
        int unsigned pc;
        int unsigned data;
        int          age;
    } op_t;

    op_t flight[$];

    task automatic tick();
        op_t n;
        @(posedge clk);
        if (rsn || flush) begin
            flight.delete();
        end else if (!hold) begin
            for (int i = flight.size() - 1; i >= 0; i--) begin
                flight[i].age++;
                if (flight[i].age > DEPTH) flight.delete(i);
            end
            if (issue_valid) begin
                longint unsigned full;
                full    = longint'(issue_a) * longint'(issue_b);
                n.addr  = int'(issue_addr);
                n.wr_en = issue_wr_en;
                n.pc    = issue_pc;
                n.data  = int'(full % 64'h1_0000_0000);
                n.age   = 1;
                flight.push_back(n);
            end
        end
        #1;
    endtask

    function automatic bit m_wb(output int addr, output int unsigned data, output int unsigned pc);
        addr = 0; data = 0; pc = 0;
        foreach (flight[i]) begin
            if (flight[i].age == DEPTH && flight[i].wr_en) begin
                addr = flight[i].addr; data = flight[i].data; pc = flight[i].pc;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void m_port(input int rd, output bit en, output bit stl, output int unsigned data);
        int best = DEPTH + 1;
        data = 0;
        if (rd != 0) begin
            foreach (flight[i]) begin
                if (flight[i].wr_en && flight[i].addr == rd && flight[i].age < best) begin
                    best = flight[i].age;
                    data = flight[i].data;
                end
            end
        end
        en  = (best == DEPTH);
        stl = (best < DEPTH);
    endfunction

    task automatic idle_inputs();
        issue_valid = 1'b0; hold = 1'b0; flush = 1'b0; rsn = 1'b0;
        issue_a = '0; issue_b = '0; issue_addr = '0; issue_wr_en = 1'b0; issue_pc = '0;
        rd_addr = '0;
    endtask

    task automatic issue(input int unsigned a, input int unsigned b, input int addr, input int unsigned pc);
        issue_valid = 1'b1; issue_a = a; issue_b = b;
        issue_addr = addr[RAW-1:0]; issue_wr_en = 1'b1; issue_pc = pc;
    endtask

    task automatic test_reset();
        idle_inputs();
        rsn = 1'b1;
        tick(); tick();
        rsn = 1'b0;
        rd_addr = {5'd3, 5'd4};
        #1;
        n_checks++;
        if ({wb_valid, byp_en, stall} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", {wb_valid, byp_en, stall});
        end
        n_checks++;
        if (wb_addr !== '0 || wb_data !== '0 || wb_pc !== '0) begin
            n_fail++; $display("FAIL reset_wb got addr=%0d data=%h pc=%h want 0", wb_addr, wb_data, wb_pc);
        end
    endtask

    task automatic test_basic();
        idle_inputs();
        issue(7, 6, 3, 32'h100);
        tick();
        idle_inputs();
        for (int c = 1; c <= 7; c++) begin
            #1;
            n_checks++;
            if (wb_valid !== (c == DEPTH)) begin
                n_fail++; $display("FAIL basic_wb_valid cycle %0d got %b want %b", c, wb_valid, c == DEPTH);
            end
            if (c == DEPTH) begin
                n_checks++;
                if (wb_addr !== 5'd3 || wb_data !== 32'd42 || wb_pc !== 32'h100) begin
                    n_fail++; $display("FAIL basic_wb got addr=%0d data=%0d pc=%h want 3/42/100", wb_addr, wb_data, wb_pc);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall_bypass();
        idle_inputs();
        issue(3, 5, 4, 32'h200);
        tick();
        idle_inputs();
        rd_addr = {5'd4, 5'd4};
        for (int c = 1; c <= DEPTH; c++) begin
            #1;
            n_checks++;
            if (stall !== (c < DEPTH) || byp_en !== ((c == DEPTH) ? 2'b11 : 2'b00)) begin
                n_fail++; $display("FAIL stall_byp cycle %0d got stall=%b en=%b", c, stall, byp_en);
            end
            if (c == DEPTH) begin
                n_checks++;
                if (byp_data !== {32'd15, 32'd15}) begin
                    n_fail++; $display("FAIL byp_data got %h want 0000000f0000000f", byp_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_youngest();
        idle_inputs();
        issue(2, 5, 4, 32'h300);
        tick();
        issue(4, 5, 4, 32'h304);
        tick();
        idle_inputs();
        tick(); tick(); tick();
        rd_addr = {5'd0, 5'd4};
        #1;
        n_checks++;
        if (stall !== 1'b1 || byp_en !== 2'b00) begin
            n_fail++; $display("FAIL youngest_shadow got stall=%b en=%b want 1/00", stall, byp_en);
        end
        tick();
        #1;
        n_checks++;
        if (stall !== 1'b0 || byp_en !== 2'b01 || byp_data[31:0] !== 32'd20) begin
            n_fail++; $display("FAIL youngest_byp got stall=%b en=%b data=%0d want 0/01/20", stall, byp_en, byp_data[31:0]);
        end
        tick();
    endtask

    task automatic test_hold_flush();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            issue(c + 1, 3, 10 + c, 32'h400 + c);
            tick();
            n_checks++;
            if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL hf_issue wb_valid=%b want 0", wb_valid); end
        end
        issue(9, 9, 15, 32'h4ff);
        hold = 1'b1;
        for (int c = 3; c < 5; c++) begin
            tick();
            n_checks++;
            if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL hf_hold wb_valid=%b want 0", wb_valid); end
        end
        flush = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            rd_addr = {5'd10 + 5'(c % 3), 5'd15};
            #1;
            n_checks++;
            if (wb_valid !== 1'b0 || stall !== 1'b0 || byp_en !== 2'b00) begin
                n_fail++; $display("FAIL hf_empty cycle %0d got wb=%b stall=%b en=%b want 0", c, wb_valid, stall, byp_en);
            end
            tick();
        end
    endtask

    task automatic test_reg0();
        idle_inputs();
        issue(32'hFFFF_FFFF, 2, 0, 32'h500);
        tick();
        idle_inputs();
        for (int c = 1; c <= 6; c++) begin
            rd_addr = '0;
            #1;
            n_checks++;
            if (stall !== 1'b0 || byp_en !== 2'b00) begin
                n_fail++; $display("FAIL reg0_query cycle %0d got stall=%b en=%b want 0", c, stall, byp_en);
            end
            if (c == DEPTH) begin
                n_checks++;
                if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FFFE) begin
                    n_fail++; $display("FAIL reg0_wb got valid=%b data=%h want 1/fffffffe", wb_valid, wb_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            issue(c + 2, 7, 20 + c, 32'h600 + c);
            tick();
        end
        rsn = 1'b1; hold = 1'b1; issue_valid = 1'b1;
        tick();
        idle_inputs();
        rd_addr = {5'd20, 5'd21};
        #1;
        n_checks++;
        if ({wb_valid, byp_en, stall} !== 4'b0 || wb_addr !== '0 || wb_data !== '0 || wb_pc !== '0) begin
            n_fail++; $display("FAIL rst_mid got wb=%b en=%b stall=%b addr=%0d data=%h pc=%h want 0",
                               wb_valid, byp_en, stall, wb_addr, wb_data, wb_pc);
        end
        for (int c = 0; c < 7; c++) begin
            tick();
            n_checks++;
            if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after cycle %0d wb_valid=%b want 0", c, wb_valid); end
        end
    endtask

    task automatic test_random();
        bit          e_wb, e_en, e_st, any_st;
        int          e_addr, rd;
        int unsigned e_data, e_pc, p_data;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_a     = $urandom;
            issue_b     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
            issue_addr  = RAW'($urandom_range(0, 7));
            issue_wr_en = ($urandom_range(0, 5) != 0);
            issue_pc    = $urandom;
            hold        = ($urandom_range(0, 7) == 0);
            flush       = ($urandom_range(0, 24) == 0);
            rsn         = ($urandom_range(0, 79) == 0);
            rd_addr     = {RAW'($urandom_range(0, 7)), RAW'($urandom_range(0, 7))};
            #1;
            e_wb = m_wb(e_addr, e_data, e_pc);
            n_checks++;
            if (wb_valid !== e_wb) begin
                n_fail++; $display("FAIL rand_wb_valid cycle %0d got %b want %b", c, wb_valid, e_wb);
            end else if (e_wb && (wb_addr !== RAW'(e_addr) || wb_data !== e_data || wb_pc !== e_pc)) begin
                n_fail++; $display("FAIL rand_wb cycle %0d got %0d/%h/%h want %0d/%h/%h",
                                   c, wb_addr, wb_data, wb_pc, e_addr, e_data, e_pc);
            end
            any_st = 1'b0;
            for (int k = 0; k < NREAD; k++) begin
                rd = int'(rd_addr[k*RAW +: RAW]);
                m_port(rd, e_en, e_st, p_data);
                any_st |= e_st;
                n_checks++;
                if (byp_en[k] !== e_en || (e_en && byp_data[k*XLEN +: XLEN] !== p_data)) begin
                    n_fail++; $display("FAIL rand_byp cycle %0d port %0d got en=%b data=%h want en=%b data=%h",
                                       c, k, byp_en[k], byp_data[k*XLEN +: XLEN], e_en, p_data);
                end
            end
            n_checks++;
            if (stall !== any_st) begin
                n_fail++; $display("FAIL rand_stall cycle %0d got %b want %b", c, stall, any_st);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_bypass();
        test_youngest();
        test_hold_flush();
        test_reg0();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_bypass_pipe.md
MULT_BYPASS_PIPE -- requirements
Module: mult_bypass_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter DEPTH, default 5, multiplier latency in stages (legal range 2..8).
REQ-003 Parameter NREAD, default 2, number of bypass query ports.
REQ-004 Parameter RAW, default 5, register address width.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rsn_i  in  1  reset, synchronous, active-high.
REQ-007 issue_valid_i  in  1  multiply issued this cycle.
REQ-008 issue_a_i, issue_b_i  in  XLEN  operands.
REQ-009 issue_addr_i  in  RAW  destination register; issue_wr_en_i  in  1  destination write enable.
REQ-010 issue_pc_i  in  32  PC carried to writeback.
REQ-011 hold_i  in  1  freeze all stages; flush_i  in  1  kill all in-flight ops.
REQ-012 rd_addr_i  in  NREAD*RAW  decode-stage source addresses, port k in bits [k*RAW +: RAW].
REQ-013 byp_en_o  out  NREAD  bypass hit per port; byp_data_o  out  NREAD*XLEN  bypass data.
REQ-014 stall_o  out  1  a source depends on an unfinished multiply.
REQ-015 wb_valid_o  out  1; wb_addr_o  out  RAW; wb_data_o  out  XLEN; wb_pc_o  out  32: writeback slot.

Function
REQ-016 The block SHALL hold DEPTH stage registers, each with valid, wr_en, addr, pc, data.
REQ-017 Stage 1 SHALL capture the low XLEN bits of issue_a_i*issue_b_i (unsigned, truncated) on an accepted issue.
REQ-018 An op SHALL advance one stage per non-held cycle; stage DEPTH drives wb_*_o, giving issue-to-wb_valid_o latency of exactly DEPTH cycles.
REQ-019 wb_valid_o SHALL be asserted only when stage DEPTH is valid and its wr_en is 1.
REQ-020 With hold_i=1 and flush_i=0, all stages SHALL keep their contents and issue_valid_i SHALL be ignored.
REQ-021 flush_i=1 SHALL clear every stage valid on the next edge, overriding hold_i and issue_valid_i.
REQ-022 Per port k, a stage matches when it is valid, wr_en=1, addr equals rd_addr k, and rd_addr k is non-zero.
REQ-023 A match in stage DEPTH SHALL assert byp_en_o[k] with that stage's data, combinationally in the same cycle.
REQ-024 A match in any stage 1..DEPTH-1 SHALL assert stall_o and deassert byp_en_o[k], since the younger result supersedes stage DEPTH.
REQ-025 Multiple matches SHALL resolve to the youngest stage (lowest index).
REQ-026 Register 0 SHALL never match, never bypass and never stall.
REQ-027 Issue during stall_o SHALL be the decode's responsibility; the block SHALL accept any issue_valid_i when hold_i=0.

Reset
REQ-028 rsn_i=1 at an edge SHALL clear all stage valid and wr_en bits, and data, addr and pc to 0.
REQ-029 After reset, wb_valid_o, byp_en_o and stall_o SHALL be 0 and wb_addr_o, wb_data_o, wb_pc_o SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight ops with no writeback; reset SHALL take priority over flush_i and hold_i.

Structure
REQ-031 XLEN, RAW and the default DEPTH SHALL be constants in the shared vi_pkg package, with a stage-record typedef.
REQ-032 One sub-module, mult_stage_reg, SHALL implement a single stage register with hold, flush and reset, instantiated DEPTH times by generate.
REQ-033 The bypass search SHALL be a single priority loop over stages, replicated per port by generate.

Verification
REQ-034 Issue a=7, b=6, addr=3 at cycle 0 -> wb_valid_o=1, wb_addr_o=3, wb_data_o=42 at cycle 5 (DEPTH=5), one cycle only.
REQ-035 Issue to addr=4; query rd_addr=4 on each following cycle -> stall_o=1 in cycles 1..4; byp_en_o=1 with data in cycle 5.
REQ-036 Issue addr=4 data 10, then addr=4 data 20 one cycle later; query 4 when first is in stage 5 -> stall_o=1, byp_en_o=0.
REQ-037 Issue at cycles 0..2, hold_i at cycles 3..4, flush_i at cycle 5 -> no wb_valid_o ever; pipe empty at cycle 6.
REQ-038 Issue addr=0 with wr_en=1 and query rd_addr=0 -> stall_o=0 and byp_en_o=0 throughout; a=0xFFFFFFFF, b=2 -> wb_data_o=0xFFFFFFFE.
REQ-039 Assert rsn_i with 3 ops in flight -> all outputs 0 on the next cycle; no writeback afterwards.
